// File: rtl/systolic_mm_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_tile_pkg
// Brief    : Shared types and default sizing for the systolic matrix tile.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_mm_tile_pkg;

   localparam int c_n_default      = 4;
   localparam int c_data_w_default = 8;
   localparam int c_acc_w_default  = 2 * c_data_w_default + 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } tile_state_t;

   typedef struct packed {
      logic                        valid;
      logic [c_data_w_default-1:0] data;
   } lane_t;

endpackage
`default_nettype wire

// File: rtl/systolic_mm_tile_pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac
// Brief    : One systolic MAC cell: registered east/south operand hop plus a
//            clearable accumulator that wraps modulo 2^ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module pe_mac
   import systolic_mm_tile_pkg::*;
#(
   parameter int DATA_W = c_data_w_default,
   parameter int ACC_W  = c_acc_w_default,
   parameter int SIGNED = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              a_valid_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              b_valid_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              a_valid_o,
   output logic [DATA_W-1:0] a_data_o,
   output logic              b_valid_o,
   output logic [DATA_W-1:0] b_data_o,
   output logic [ACC_W-1:0]  acc_o
);

   localparam logic c_sext = (SIGNED != 0);

   logic              r_a_valid;
   logic [DATA_W-1:0] r_a_data;
   logic              r_b_valid;
   logic [DATA_W-1:0] r_b_data;
   logic [ACC_W-1:0]  r_acc;

   logic [2*DATA_W-1:0] w_a_ext;
   logic [2*DATA_W-1:0] w_b_ext;
   logic [2*DATA_W-1:0] w_prod;
   logic [ACC_W-1:0]    w_addend;

   // Extending to full product width first makes the low 2*DATA_W bits of the
   // multiply exact for both signed and unsigned operands.
   assign w_a_ext  = {{DATA_W{c_sext & a_data_i[DATA_W-1]}}, a_data_i};
   assign w_b_ext  = {{DATA_W{c_sext & b_data_i[DATA_W-1]}}, b_data_i};
   assign w_prod   = w_a_ext * w_b_ext;
   assign w_addend = c_sext ? ACC_W'($signed(w_prod)) : ACC_W'(w_prod);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_a_valid <= 1'b0;
         r_a_data  <= '0;
         r_b_valid <= 1'b0;
         r_b_data  <= '0;
         r_acc     <= '0;
      end else begin
         r_a_valid <= a_valid_i;
         r_a_data  <= a_data_i;
         r_b_valid <= b_valid_i;
         r_b_data  <= b_data_i;
         if (clr_i) begin
            r_acc <= '0;
         end else if (a_valid_i & b_valid_i) begin
            r_acc <= r_acc + w_addend;
         end
      end
   end

   assign a_valid_o = r_a_valid;
   assign a_data_o  = r_a_data;
   assign b_valid_o = r_b_valid;
   assign b_data_o  = r_b_data;
   assign acc_o     = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_mm_tile.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_tile
// Brief    : Output-stationary N x N systolic tile computing C = A * B for a
//            runtime K, with skewed injection and a row-serial result drain.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_mm_tile
   import systolic_mm_tile_pkg::*;
#(
   parameter int N      = c_n_default,
   parameter int DATA_W = c_data_w_default,
   parameter int ACC_W  = c_acc_w_default,
   parameter int K_MAX  = 256,
   parameter int SIGNED = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [$clog2(K_MAX+1)-1:0] k_len_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [N*DATA_W-1:0]        a_col_i,
   input  logic [N*DATA_W-1:0]        b_row_i,
   output logic                       c_valid_o,
   input  logic                       c_ready_i,
   output logic [N*ACC_W-1:0]         c_row_o,
   output logic [$clog2(N)-1:0]       c_idx_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int c_kw = $clog2(K_MAX + 1);
   localparam int c_iw = $clog2(N);
   localparam int c_fw = $clog2(2 * N);

   tile_state_t     r_state;
   logic [c_kw-1:0] r_k_len;
   logic [c_kw-1:0] r_beat;
   logic [c_fw-1:0] r_flush;
   logic [c_iw-1:0] r_idx;
   logic            r_in_ready;
   logic            r_c_valid;
   logic            r_busy;
   logic            r_done;

   logic            w_accept;
   logic            w_start;
   logic [c_kw-1:0] w_beat_nxt;

   // w_*[i][j] is the operand arriving at PE (i,j) this cycle.
   logic              w_a_v [N][N];
   logic [DATA_W-1:0] w_a_d [N][N];
   logic              w_b_v [N][N];
   logic [DATA_W-1:0] w_b_d [N][N];
   logic [ACC_W-1:0]  w_acc [N][N];

   logic              w_east_unused_v  [N];
   logic [DATA_W-1:0] w_east_unused_d  [N];
   logic              w_south_unused_v [N];
   logic [DATA_W-1:0] w_south_unused_d [N];

   logic [N*ACC_W-1:0] w_row;

   assign w_accept   = in_valid_i & r_in_ready;
   // The done cycle is still treated as the tail of the previous product.
   assign w_start    = start_i & (r_state == IDLE) & ~r_done;
   assign w_beat_nxt = r_beat + 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign w_a_v[0][0] = w_accept;
         assign w_a_d[0][0] = w_accept ? a_col_i[0 +: DATA_W] : '0;
         assign w_b_v[0][0] = w_accept;
         assign w_b_d[0][0] = w_accept ? b_row_i[0 +: DATA_W] : '0;
      end else begin : g_delay
         logic              r_av [i];
         logic [DATA_W-1:0] r_ad [i];
         logic              r_bv [i];
         logic [DATA_W-1:0] r_bd [i];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int k = 0; k < i; k++) begin
                  r_av[k] <= 1'b0;
                  r_ad[k] <= '0;
                  r_bv[k] <= 1'b0;
                  r_bd[k] <= '0;
               end
            end else begin
               r_av[0] <= w_accept;
               r_ad[0] <= w_accept ? a_col_i[i*DATA_W +: DATA_W] : '0;
               r_bv[0] <= w_accept;
               r_bd[0] <= w_accept ? b_row_i[i*DATA_W +: DATA_W] : '0;
               for (int k = 1; k < i; k++) begin
                  r_av[k] <= r_av[k-1];
                  r_ad[k] <= r_ad[k-1];
                  r_bv[k] <= r_bv[k-1];
                  r_bd[k] <= r_bd[k-1];
               end
            end
         end

         assign w_a_v[i][0] = r_av[i-1];
         assign w_a_d[i][0] = r_ad[i-1];
         assign w_b_v[0][i] = r_bv[i-1];
         assign w_b_d[0][i] = r_bd[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic              w_ao_v;
         logic [DATA_W-1:0] w_ao_d;
         logic              w_bo_v;
         logic [DATA_W-1:0] w_bo_d;

         pe_mac #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
         ) u_pe (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clr_i     (w_start),
            .a_valid_i (w_a_v[i][j]),
            .a_data_i  (w_a_d[i][j]),
            .b_valid_i (w_b_v[i][j]),
            .b_data_i  (w_b_d[i][j]),
            .a_valid_o (w_ao_v),
            .a_data_o  (w_ao_d),
            .b_valid_o (w_bo_v),
            .b_data_o  (w_bo_d),
            .acc_o     (w_acc[i][j])
         );

         if (j < N - 1) begin : g_east
            assign w_a_v[i][j+1] = w_ao_v;
            assign w_a_d[i][j+1] = w_ao_d;
         end else begin : g_east_edge
            assign w_east_unused_v[i] = w_ao_v;
            assign w_east_unused_d[i] = w_ao_d;
         end

         if (i < N - 1) begin : g_south
            assign w_b_v[i+1][j] = w_bo_v;
            assign w_b_d[i+1][j] = w_bo_d;
         end else begin : g_south_edge
            assign w_south_unused_v[j] = w_bo_v;
            assign w_south_unused_d[j] = w_bo_d;
         end
      end
   end

   always_comb begin
      w_row = '0;
      for (int j = 0; j < N; j++) begin
         w_row[j*ACC_W +: ACC_W] = w_acc[r_idx][j];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_k_len    <= '0;
         r_beat     <= '0;
         r_flush    <= '0;
         r_idx      <= '0;
         r_in_ready <= 1'b0;
         r_c_valid  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_k_len <= k_len_i;
                  r_beat  <= '0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  if (k_len_i == '0) begin
                     r_state   <= DRAIN;
                     r_c_valid <= 1'b1;
                  end else begin
                     r_state    <= FEED;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            FEED: begin
               if (w_accept) begin
                  r_beat <= w_beat_nxt;
                  if (w_beat_nxt == r_k_len) begin
                     r_state    <= FLUSH;
                     r_in_ready <= 1'b0;
                     r_flush    <= '0;
                  end
               end
            end
            FLUSH: begin
               // 2N-1 cycles lets the last beat reach PE (N-1,N-1).
               if (r_flush == c_fw'(2 * N - 2)) begin
                  r_state   <= DRAIN;
                  r_c_valid <= 1'b1;
               end else begin
                  r_flush <= r_flush + 1'b1;
               end
            end
            DRAIN: begin
               if (c_ready_i) begin
                  if (r_idx == c_iw'(N - 1)) begin
                     r_state   <= IDLE;
                     r_c_valid <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_idx     <= '0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready_o = r_in_ready;
   assign c_valid_o  = r_c_valid;
   assign c_row_o    = w_row;
   assign c_idx_o    = r_idx;
   assign busy_o     = r_busy;
   assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_tile.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_mm_tile
// Brief    : Self-checking bench; expected rows come from a plain matrix
//            product of the operands kept here, reduced modulo 2^ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_tile;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 16;
   localparam int KM = 256;
   localparam int KW = $clog2(KM + 1);
   localparam int KT = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_col;
   logic [N*DW-1:0] b_row;
   logic            c_valid;
   logic            c_ready;
   logic [N*AW-1:0] c_row;
   logic [1:0]      c_idx;
   logic            busy;
   logic            done;

   int total = 0;
   int bad   = 0;
   int am [N][KT];
   int bm [KT][N];

   always #5 clk = ~clk;

   systolic_mm_tile #(
      .N      (N),
      .DATA_W (DW),
      .ACC_W  (AW),
      .K_MAX  (KM),
      .SIGNED (1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .k_len_i    (k_len),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .a_col_i    (a_col),
      .b_row_i    (b_row),
      .c_valid_o  (c_valid),
      .c_ready_i  (c_ready),
      .c_row_o    (c_row),
      .c_idx_o    (c_idx),
      .busy_o     (busy),
      .done_o     (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_row(input int r, input int k);
      logic [63:0] row;
      logic [31:0] sv;
      int          s;
      row = '0;
      for (int j = 0; j < N; j++) begin
         s = 0;
         for (int kk = 0; kk < k; kk++) s += am[r][kk] * bm[kk][j];
         sv = s;
         row[j*AW +: AW] = sv[AW-1:0];
      end
      return row;
   endfunction

   // vmode: 0 always valid, 1 every other cycle, 2 random
   task automatic feed(input int k, input int vmode, input string tag);
      int   beat;
      int   cyc;
      int   flushc;
      int   t;
      logic v;
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(k);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      beat = 0;
      cyc  = 0;
      while (beat < k && cyc < 400) begin
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         in_valid = v;
         for (int i = 0; i < N; i++) begin
            t = am[i][beat];
            a_col[i*DW +: DW] = v ? t[DW-1:0] : DW'($urandom);
            t = bm[beat][i];
            b_row[i*DW +: DW] = v ? t[DW-1:0] : DW'($urandom);
         end
         if (v && in_ready) beat++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      a_col    = N*DW'($urandom);
      chk({tag, "_beats"}, beat, k);
      if (k > 0) begin
         chk({tag, "_ready_drop"}, in_ready, 0);
         flushc = 0;
         while (!c_valid && flushc < 100) begin
            flushc++;
            @(negedge clk);
         end
         chk({tag, "_flush_len"}, flushc, 2 * N - 1);
      end
   endtask

   // smode: 0 always ready, 1 five stall cycles at row 0, 2 random
   task automatic drain(input int k, input int smode, input string tag);
      int r;
      int cyc;
      int stall;
      r     = 0;
      cyc   = 0;
      stall = 0;
      while (r < N && cyc < 200) begin
         chk({tag, "_valid"}, c_valid, 1);
         chk({tag, "_idx"}, c_idx, r);
         chk({tag, "_row"}, c_row, exp_row(r, k));
         chk({tag, "_no_early_done"}, done, 0);
         if (smode == 1 && r == 0 && stall < 5) begin
            c_ready = 1'b0;
            stall++;
         end else if (smode == 2) begin
            c_ready = 1'($urandom_range(0, 1));
         end else begin
            c_ready = 1'b1;
         end
         if (c_ready) r++;
         @(negedge clk);
         cyc++;
      end
      c_ready = 1'b0;
      chk({tag, "_rows"}, r, N);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_valid"}, c_valid, 0);
   endtask

   task automatic run(input int k, input int vmode, input int smode, input string tag);
      feed(k, vmode, tag);
      drain(k, smode, tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      k_len    = '0;
      in_valid = 1'b0;
      a_col    = '0;
      b_row    = '0;
      c_ready  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_c_idx", c_idx, 0);
      chk("rst_c_row", c_row, 0);
      rst = 1'b0;

      // Column of A = 1..4, row of B all ones
      for (int i = 0; i < N; i++) begin
         am[i][0] = i + 1;
         bm[0][i] = 1;
      end
      run(1, 0, 0, "t1");

      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            am[i][k] = (i == k) ? 1 : 0;
            bm[k][i] = 4 * k + i + 1;
         end
      run(4, 0, 0, "t2");
      run(4, 1, 0, "t3");

      for (int i = 0; i < N; i++) begin
         am[i][0] = i + 1;
         bm[0][i] = 1;
      end
      feed(1, 0, "t4");
      drain(1, 1, "t4");

      // Back-to-back: start in the done cycle is ignored, next cycle accepted
      start = 1'b1;
      k_len = '0;
      @(negedge clk);
      chk("b2b_ignored_busy", busy, 0);
      chk("b2b_ignored_valid", c_valid, 0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept_busy", busy, 1);
      drain(0, 0, "b2b");
      @(negedge clk);
      chk("b2b_done_pulse", done, 0);

      // Wrap: 2 * (-128 * -128) = 32768 -> 16'h8000
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 2; k++) begin
            am[i][k] = -128;
            bm[k][i] = -128;
         end
      run(2, 0, 0, "t5");

      for (int n = 0; n < 6; n++) begin
         int k;
         k = $urandom_range(1, 12);
         for (int i = 0; i < N; i++)
            for (int kk = 0; kk < KT; kk++) begin
               am[i][kk] = int'($urandom_range(0, 255)) - 128;
               bm[kk][i] = int'($urandom_range(0, 255)) - 128;
            end
         run(k, 2, 2, "rnd");
      end

      // Reset in the middle of FEED
      feed(0, 0, "pre");
      drain(0, 0, "pre");
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(8);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      a_col    = {8'd3, 8'd3, 8'd3, 8'd3};
      b_row    = {8'd5, 8'd5, 8'd5, 8'd5};
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_c_valid", c_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_c_idx", c_idx, 0);
      chk("mid_rst_c_row", c_row, 0);
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
      run(0, 0, 0, "t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
